// File: rtl/spi_master_engine_pkg.sv
// Shared types and default constants for the SPI master engine.
// Contents: state_t (engine FSM states), DEF_DATA_WIDTH, DEF_CLK_DIV.
// Optional feature macro: SPI_MASTER_ENGINE_BURST_EN adds the HELD state.
package spi_master_engine_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
`ifdef SPI_MASTER_ENGINE_BURST_EN
    ,
    ST_HELD
`endif
  } state_t;

endpackage

// File: rtl/spi_master_engine_sclk_tick.sv
// Half-period tick generator for the SPI master engine.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - counting enable; while low the counter sits at its reload value
//   tick - one-cycle pulse every CLK_DIV enabled cycles
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'(CLK_DIV - 1);
    end else if (!en || cnt == 8'd0) begin
      cnt <= 8'(CLK_DIV - 1);
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = en && (cnt == 8'd0);

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master engine: one DATA_WIDTH-bit full-duplex transfer per
// accepted start, MSB first, with setup/hold guard periods around the burst.
// Parameters: CLK_DIV (clk cycles per SCLK half period, 2..255), DATA_WIDTH.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - one-cycle transfer request (accepted in IDLE)
//   slave_sel, tx_data  - target index and word, sampled on accepted start
//   rx_data             - last received word, updated with done
//   busy, done          - transfer in progress / one-cycle completion pulse
//   spi_select          - slave index to the chip-select decoder
//   spi_master_active_n - active-low transfer enable to the decoder
//   spi_sclk, spi_mosi, spi_miso - SPI bus
// Optional feature macro SPI_MASTER_ENGINE_BURST_EN adds:
//   keep_active - sampled at start; stay selected (HELD) after the word
//   release_req - leave HELD; named release_req because "release" is a
//                 reserved word in SystemVerilog
module spi_master_engine
  import spi_master_engine_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            slave_sel,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            spi_select,
  output logic                  spi_master_active_n,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
`ifdef SPI_MASTER_ENGINE_BURST_EN
  input  logic                  keep_active,
  input  logic                  release_req,
`endif
  input  logic                  spi_miso
);

  localparam int HW = $clog2(2 * DATA_WIDTH);
  localparam logic [HW-1:0] H_LAST = HW'(2 * DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic [HW-1:0]         hcnt;
  logic                  tick, tick_en;
  logic                  load_tx, load_sel, sample, advance, finish;
`ifdef SPI_MASTER_ENGINE_BURST_EN
  logic                  keep_q;
`endif

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_tx  = 1'b0;
    load_sel = 1'b0;
    finish   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          load_tx  = 1'b1;
          load_sel = 1'b1;
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && hcnt == H_LAST) state_d = ST_HOLD;
      ST_HOLD: begin
        if (tick) begin
          finish = 1'b1;
`ifdef SPI_MASTER_ENGINE_BURST_EN
          state_d = keep_q ? ST_HELD : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SPI_MASTER_ENGINE_BURST_EN
      ST_HELD: begin
        // release has priority over a coincident start
        if (release_req) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_SHIFT;
          load_tx = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Even half-period index = SCLK low; its tick is the rising edge.
  assign sample  = (state_q == ST_SHIFT) && tick && !hcnt[0];
  assign advance = (state_q == ST_SHIFT) && tick && hcnt[0] && (hcnt != H_LAST);

`ifdef SPI_MASTER_ENGINE_BURST_EN
  assign tick_en = (state_q != ST_IDLE) && (state_q != ST_HELD);
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HELD);
`else
  assign tick_en = (state_q != ST_IDLE);
  assign busy    = (state_q != ST_IDLE);
`endif

  assign spi_master_active_n = (state_q == ST_IDLE);
  assign spi_sclk            = (state_q == ST_SHIFT) && hcnt[0];
  assign spi_mosi            = busy ? tx_sr[DATA_WIDTH-1] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      hcnt       <= '0;
      spi_select <= '0;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (finish)   rx_data    <= rx_sr;
      if (load_sel) spi_select <= slave_sel;
      if (load_tx) begin
        tx_sr <= tx_data;
        hcnt  <= '0;
      end else begin
        if (advance) tx_sr <= tx_sr << 1;
        if ((state_q == ST_SHIFT) && tick) hcnt <= hcnt + 1'b1;
      end
      if (sample) rx_sr <= DATA_WIDTH'({rx_sr, spi_miso});
    end
  end

`ifdef SPI_MASTER_ENGINE_BURST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          keep_q <= 1'b0;
    else if (load_tx) keep_q <= keep_active;
  end
`endif

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine (CLK_DIV=4 main instance and a
// CLK_DIV=2 instance with MISO looped back to MOSI).
module tb_spi_master_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, CLK_DIV = 4
  logic       start = 1'b0;
  logic [2:0] slave_sel = '0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  logic       busy, done, active_n, sclk, mosi, miso;
  logic [2:0] spi_select;
`ifdef SPI_MASTER_ENGINE_BURST_EN
  logic       keep_active = 1'b0;
  logic       release_req = 1'b0;
`endif

  // second instance, CLK_DIV = 2
  logic       start2 = 1'b0;
  logic [2:0] slave_sel2 = 3'd5;
  logic [7:0] tx2 = '0;
  logic [7:0] rx2;
  logic       busy2, done2, an2, sclk2, mosi2;
  logic [2:0] sel2;

  spi_master_engine #(.CLK_DIV(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .spi_select(spi_select), .spi_master_active_n(active_n),
    .spi_sclk(sclk), .spi_mosi(mosi),
`ifdef SPI_MASTER_ENGINE_BURST_EN
    .keep_active(keep_active), .release_req(release_req),
`endif
    .spi_miso(miso)
  );

  spi_master_engine #(.CLK_DIV(2), .DATA_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .slave_sel(slave_sel2),
    .tx_data(tx2), .rx_data(rx2), .busy(busy2), .done(done2),
    .spi_select(sel2), .spi_master_active_n(an2),
    .spi_sclk(sclk2), .spi_mosi(mosi2),
`ifdef SPI_MASTER_ENGINE_BURST_EN
    .keep_active(1'b0), .release_req(1'b0),
`endif
    .spi_miso(mosi2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard of accepted transfers
  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // SPI mode-0 slave model: preloads sl_word while deselected, shifts MISO
  // on falling SCLK, captures MOSI on rising SCLK, reloads after 8 bits.
  logic [7:0] sl_word = '0;
  logic [7:0] sl_sr = '0;
  logic [7:0] cap = '0;
  logic       sclk_q = 1'b0;
  int         sl_cnt = 0;
  assign miso = sl_sr[7];

  always @(posedge clk) begin
    sclk_q <= sclk;
    if (active_n) begin
      sl_sr  <= sl_word;
      sl_cnt <= 0;
    end else if (sclk && !sclk_q) begin
      cap    <= {cap[6:0], mosi};
      sl_cnt <= sl_cnt + 1;
    end else if (!sclk && sclk_q) begin
      if (sl_cnt == 8) begin
        sl_sr  <= sl_word;
        sl_cnt <= 0;
      end else begin
        sl_sr <= sl_sr << 1;
      end
    end
  end

  // monitor for the main instance
  int done_cnt = 0, low_len = 0, last_low = 0, high_len = 0, last_high = 0, rise_cnt = 0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("done_without_request", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check_val("rx_data", rx_data, mon_e.rx);
        check_val("spi_select", spi_select, mon_e.sel);
        check_val("mosi_bits", cap, mon_e.tx);
      end
    end
    if (!active_n) begin
      if (high_len != 0) last_high = high_len;
      high_len = 0;
      low_len++;
    end else begin
      if (low_len != 0) begin
        last_low = low_len;
        rise_cnt++;
      end
      low_len = 0;
      high_len++;
    end
  end

  // monitor for the CLK_DIV=2 instance
  int low2 = 0, last_low2 = 0, cyc2 = 0, period2 = 0;
  logic sclk2_q = 1'b0;
  always @(negedge clk) begin
    if (!an2) low2++;
    else begin
      if (low2 != 0) last_low2 = low2;
      low2 = 0;
    end
    cyc2++;
    if (sclk2 && !sclk2_q) begin
      period2 = cyc2;
      cyc2 = 0;
    end
    sclk2_q = sclk2;
  end

  task automatic go(input logic [2:0] sel, input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    e.sel = sel; e.tx = tx; e.rx = rx;
    start = 1'b1; slave_sel = sel; tx_data = tx;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_val("done_seen", done, 1);
  endtask

  int d0, r0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_active_n", active_n, 1);
    check_val("rst_sclk", sclk, 0);
    check_val("rst_mosi", mosi, 0);
    check_val("rst_select", spi_select, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_rx", rx_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic transfer
    sl_word = 8'h3C; d0 = done_cnt;
    go(3'd3, 8'hA5, 8'h3C);
    check_val("busy_after_start", busy, 1);
    check_val("active_n_after_start", active_n, 0);
    wait_done(200);
    @(negedge clk);
    check_val("done_one_cycle", done, 0);
    check_val("done_count_t1", done_cnt - d0, 1);
    check_val("active_low_len_t1", last_low, 72);

    // start while busy is ignored
    sl_word = 8'hC3; d0 = done_cnt;
    go(3'd3, 8'h5A, 8'hC3);
    repeat (8) @(negedge clk);
    start = 1'b1; slave_sel = 3'd5; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_ignored_start", busy, 1);
    check_val("select_ignored_start", spi_select, 3);
    wait_done(200);
    @(negedge clk);
    check_val("done_count_t2", done_cnt - d0, 1);
    check_val("select_after_t2", spi_select, 3);

    // reset in the middle of a transfer
    sl_word = 8'h77; d0 = done_cnt;
    go(3'd6, 8'h11, 8'h77);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_active_n", active_n, 1);
    check_val("midrst_sclk", sclk, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_rx", rx_data, 0);
    check_val("midrst_select", spi_select, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    check_val("midrst_no_done", done_cnt - d0, 0);
    check_val("midrst_rx_after", rx_data, 0);

    // back-to-back transfers with start held in the done cycle
    sl_word = 8'h96; d0 = done_cnt;
    go(3'd2, 8'hFF, 8'h96);
    sl_word = 8'h69;
    wait_done(200);
    begin
      exp_t e;
      e.sel = 3'd4; e.tx = 8'h00; e.rx = 8'h69;
      start = 1'b1; slave_sel = 3'd4; tx_data = 8'h00;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    @(negedge clk);
    check_val("b2b_gap", last_high, 1);
    check_val("b2b_low_len", last_low, 72);
    check_val("b2b_done_count", done_cnt - d0, 2);

    // minimum divider, loopback
    start2 = 1'b1; tx2 = 8'h81;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done2) break;
    end
    check_val("div2_done_seen", done2, 1);
    @(negedge clk);
    check_val("div2_rx", rx2, 8'h81);
    check_val("div2_low_len", last_low2, 36);
    check_val("div2_sclk_period", period2, 4);
    check_val("div2_select", sel2, 5);

`ifdef SPI_MASTER_ENGINE_BURST_EN
    // burst: two words under one select, then release
    sl_word = 8'hA1; keep_active = 1'b1; d0 = done_cnt; r0 = rise_cnt;
    go(3'd1, 8'h12, 8'hA1);
    sl_word = 8'h5E;
    wait_done(200);
    check_val("held_active_n", active_n, 0);
    check_val("held_busy", busy, 0);
    begin
      exp_t e;
      e.sel = 3'd1; e.tx = 8'h34; e.rx = 8'h5E;
      start = 1'b1; slave_sel = 3'd7; tx_data = 8'h34;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (3) @(negedge clk);
    check_val("held2_active_n", active_n, 0);
    check_val("held2_select", spi_select, 1);
    release_req = 1'b1; start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    release_req = 1'b0; start = 1'b0;
    check_val("release_active_n", active_n, 1);
    check_val("release_busy", busy, 0);
    @(negedge clk);
    check_val("burst_single_rise", rise_cnt - r0, 1);
    check_val("burst_done_count", done_cnt - d0, 2);
    keep_active = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
